// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: grants one op at a time,
// drives the ALU for one cycle and holds the result until the owner takes it.
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every contention.
module alu_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            busy,
  output logic            last_grant
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic            grant_vld;
  logic            grant_id;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic            id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant selection, combinational ready and state sequencing
  always_comb begin
    state_nxt  = state;
    grant_vld  = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          grant_vld = 1'b1;
          if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_grant;
`endif
          end else begin
            grant_id = req1_valid;
          end
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        // only the owner's consume counts; the other ready is ignored
        if (id_q ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 4'd0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (grant_vld) begin
        op_q       <= grant_id ? req1_op : req0_op;
        a_q        <= grant_id ? req1_a  : req0_a;
        b_q        <= grant_id ? req1_b  : req0_b;
        id_q       <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
    end
  end

  // ALU inputs always reflect the captured operation, never a zeroed bus
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = (state != IDLE);
  assign rsp0_valid = (state == RESP) && !id_q;
  assign rsp1_valid = (state == RESP) && id_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, 32, operand/result width.
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: reqN_valid  in  1  requester N (N=0,1) holds an operation.
REQ-005 Port: reqN_ready  out  1  requester N accepted this cycle.
REQ-006 Port: reqN_op  in  4  ALU opcode, standard 4-bit ALU encoding.
REQ-007 Port: reqN_a, reqN_b  in  XLEN  operands.
REQ-008 Port: rspN_valid  out  1  result for requester N available.
REQ-009 Port: rspN_ready  in  1  requester N consumes result.
REQ-010 Port: rsp_result  out  XLEN  shared result bus; rsp_zero  out  1  shared zero flag.
REQ-011 Port: alu_op  out  4; alu_a, alu_b  out  XLEN  drive to the external combinational ALU.
REQ-012 Port: alu_result  in  XLEN; alu_zero  in  1  returned from the ALU in the same cycle.
REQ-013 Port: busy  out  1  high in any state other than IDLE; last_grant  out  1  ID of last granted requester.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; one operation outstanding at most.
REQ-015 IDLE: if any reqN_valid, grant one requester; reqN_ready SHALL be combinational, high only for the granted N, only in IDLE.
REQ-016 Handshake reqN_valid & reqN_ready SHALL capture op, a, b, and the grant ID into internal registers, update last_grant, and move to EXEC.
REQ-017 Round-robin: when both valid, grant requester != last_grant; when one valid, grant it.
REQ-018 EXEC (one cycle): alu_op/alu_a/alu_b SHALL equal the captured values; alu_result/alu_zero SHALL be registered into rsp_result/rsp_zero; move to RESP.
REQ-019 Outside EXEC, alu_op/alu_a/alu_b SHALL still present the captured registers (no toggling to zero).
REQ-020 RESP: rspN_valid high only for the captured ID; rsp_result/rsp_zero held stable until rspN_valid & rspN_ready, then return to IDLE.
REQ-021 Latency: request accepted at cycle T -> rspN_valid first high at T+2; earliest next acceptance is the cycle after the response handshake.
REQ-022 rspM_ready for the non-owning requester SHALL be ignored.
REQ-023 reqN_valid deasserted before grant SHALL not be penalised; no request is dropped or duplicated.
REQ-024 Operands are passed bit-exact; the block SHALL not inspect or alter opcodes, including unused ones.

Reset
REQ-025 rst high SHALL immediately force state IDLE, all reqN_ready/rspN_valid 0, busy 0, last_grant 1, rsp_result 0, rsp_zero 0, captured op/a/b 0.
REQ-026 rst mid-operation (EXEC or RESP) SHALL abort the operation with no response delivered; first grant after reset goes to requester 0 if both valid.

Configuration
REQ-027 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both valid; last_grant still updates.
REQ-028 ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-017.

Verification
REQ-029 Reset, req0 ADD(op 0000) a=5 b=7 -> req0_ready at T, rsp0_valid at T+2, rsp_result=12, rsp_zero=0.
REQ-030 Both valid continuously, req0 SUB 9-9, req1 OR 0xF0|0x0F -> grants alternate 0,1,0; results 0 (zero=1) and 0xFF.
REQ-031 rsp1_ready held low 5 cycles in RESP -> rsp_result stable, busy=1, no reqN_ready during stall.
REQ-032 rst asserted in EXEC -> all outputs at reset values same cycle, no rspN_valid afterwards.
REQ-033 ALU_ARB_FIXED_PRIO_EN defined, both valid for 3 ops -> requester 0 granted every time.
REQ-034 SRA 0x80000000 by 4 via req1 -> rsp_result=0xF8000000, rsp0_valid never asserted.
